// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM-stage state encoding, register-address width
// and the default data path width.
package pipeline_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Word accesses must have the two low address bits clear.
  function automatic logic word_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Cycle counter for an open memory access; saturates at TIMEOUT-1 and raises
// expired there so the owner can abort the request.
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_reg;

  assign expired = (count_reg == CW'(TIMEOUT - 1));

  // Holding at the terminal value keeps the counter from wrapping.
  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a variable-latency req/ack port,
// stalls upstream while an access is open and registers the MEM/WB fields.
module mem_access_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  RegWrite_i,
  input  logic                  MemWrite_i,
  input  logic                  MemRead_i,
  input  logic                  Mem2Reg_i,
  input  logic [DATA_W-1:0]     ALU_data_i,
  input  logic [DATA_W-1:0]     writeData_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_W-1:0]     mem_addr_o,
  output logic [DATA_W-1:0]     mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_W-1:0]     mem_rdata_i,
  output logic                  stall_o,
  output logic                  RegWrite_o,
  output logic                  Mem2Reg_o,
  output logic [DATA_W-1:0]     ALU_data_o,
  output logic [DATA_W-1:0]     ReadData_o,
  output logic [REG_ADDR_W-1:0] RDaddr_o,
  output logic                  err_o
);

  mem_state_e state_reg, state_next;
  logic                  req_reg, req_next, we_reg, we_next;
  logic [DATA_W-1:0]     addr_reg, addr_next, wdata_reg, wdata_next;
  logic                  lat_rw_reg, lat_rw_next, lat_m2r_reg, lat_m2r_next;
  logic [DATA_W-1:0]     lat_alu_reg, lat_alu_next;
  logic [REG_ADDR_W-1:0] lat_rd_reg, lat_rd_next;
  logic                  wb_rw_reg, wb_rw_next, wb_m2r_reg, wb_m2r_next;
  logic [DATA_W-1:0]     wb_alu_reg, wb_alu_next, wb_rdata_reg, wb_rdata_next;
  logic [REG_ADDR_W-1:0] wb_rd_reg, wb_rd_next;
  logic                  err_reg, err_next;
  logic                  stall, access, misaligned;
  logic                  ctr_clear, ctr_enable, ctr_expired;

  assign access     = MemRead_i | MemWrite_i;
  assign misaligned = access & word_misaligned(ALU_data_i[1:0]);

  mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk_i),
    .srst    (rst_i),
    .clear   (ctr_clear),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  always_comb begin
    state_next    = state_reg;
    req_next      = req_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    lat_rw_next   = lat_rw_reg;
    lat_m2r_next  = lat_m2r_reg;
    lat_alu_next  = lat_alu_reg;
    lat_rd_next   = lat_rd_reg;
    wb_rw_next    = wb_rw_reg;
    wb_m2r_next   = wb_m2r_reg;
    wb_alu_next   = wb_alu_reg;
    wb_rdata_next = wb_rdata_reg;
    wb_rd_next    = wb_rd_reg;
    err_next      = 1'b0;
    stall         = 1'b0;
    ctr_clear     = 1'b0;
    ctr_enable    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!access || misaligned) begin
          // Pass-through; a misaligned access is squashed to a non-writing slot.
          wb_rw_next  = RegWrite_i & ~misaligned;
          wb_m2r_next = Mem2Reg_i;
          wb_alu_next = ALU_data_i;
          wb_rd_next  = RDaddr_i;
          err_next    = misaligned;
        end else begin
          stall        = 1'b1;
          req_next     = 1'b1;
          we_next      = MemWrite_i;
          addr_next    = ALU_data_i;
          wdata_next   = writeData_i;
          lat_rw_next  = RegWrite_i;
          lat_m2r_next = Mem2Reg_i;
          lat_alu_next = ALU_data_i;
          lat_rd_next  = RDaddr_i;
          wb_rw_next   = 1'b0;
          ctr_clear    = 1'b1;
          state_next   = WAIT;
        end
      end
      WAIT: begin
        stall      = ~mem_ack_i;
        ctr_enable = 1'b1;
        wb_rw_next = 1'b0;
        if (mem_ack_i) begin
          req_next    = 1'b0;
          wb_rw_next  = lat_rw_reg;
          wb_m2r_next = lat_m2r_reg;
          wb_alu_next = lat_alu_reg;
          wb_rd_next  = lat_rd_reg;
          if (!we_reg) wb_rdata_next = mem_rdata_i;
          state_next  = IDLE;
        end else if (ctr_expired) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      req_reg      <= 1'b0;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      lat_rw_reg   <= 1'b0;
      lat_m2r_reg  <= 1'b0;
      lat_alu_reg  <= '0;
      lat_rd_reg   <= '0;
      wb_rw_reg    <= 1'b0;
      wb_m2r_reg   <= 1'b0;
      wb_alu_reg   <= '0;
      wb_rdata_reg <= '0;
      wb_rd_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      req_reg      <= req_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
      lat_rw_reg   <= lat_rw_next;
      lat_m2r_reg  <= lat_m2r_next;
      lat_alu_reg  <= lat_alu_next;
      lat_rd_reg   <= lat_rd_next;
      wb_rw_reg    <= wb_rw_next;
      wb_m2r_reg   <= wb_m2r_next;
      wb_alu_reg   <= wb_alu_next;
      wb_rdata_reg <= wb_rdata_next;
      wb_rd_reg    <= wb_rd_next;
      err_reg      <= err_next;
    end
  end

  assign stall_o     = stall;
  assign mem_req_o   = req_reg;
  assign mem_we_o    = we_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_wdata_o = wdata_reg;
  assign RegWrite_o  = wb_rw_reg;
  assign Mem2Reg_o   = wb_m2r_reg;
  assign ALU_data_o  = wb_alu_reg;
  assign ReadData_o  = wb_rdata_reg;
  assign RDaddr_o    = wb_rd_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, randomized transactions
// against a transaction-level model, and a reset-during-access sequence.
module tb_mem_access_stage;

  localparam int TO = 16;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        RegWrite_i = 0, MemWrite_i = 0, MemRead_i = 0, Mem2Reg_i = 0;
  logic [31:0] ALU_data_i = '0, writeData_i = '0;
  logic [4:0]  RDaddr_i = '0;
  logic        mem_req_o, mem_we_o, mem_ack_i = 0;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i = '0;
  logic        stall_o, RegWrite_o, Mem2Reg_o, err_o;
  logic [31:0] ALU_data_o, ReadData_o;
  logic [4:0]  RDaddr_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mem_access_stage #(.DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .RegWrite_i(RegWrite_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
    .Mem2Reg_i(Mem2Reg_i), .ALU_data_i(ALU_data_i), .writeData_i(writeData_i),
    .RDaddr_i(RDaddr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .RegWrite_o(RegWrite_o), .Mem2Reg_o(Mem2Reg_o),
    .ALU_data_o(ALU_data_o), .ReadData_o(ReadData_o), .RDaddr_o(RDaddr_o),
    .err_o(err_o)
  );

  // lat: WAIT cycle (1-based) in which ack arrives; 0 = never.
  typedef struct {
    string       name;
    logic        rd, wr, rw, m2r;
    logic [31:0] alu, wdata;
    logic [4:0]  rdd;
    int          lat;
    logic [31:0] rdata;
    int          exp_stall;
    logic        exp_err, exp_rw, exp_req;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_inputs(input vec_t v);
    MemRead_i = v.rd; MemWrite_i = v.wr; RegWrite_i = v.rw; Mem2Reg_i = v.m2r;
    ALU_data_i = v.alu; writeData_i = v.wdata; RDaddr_i = v.rdd;
  endtask

  task automatic drive_nop();
    MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; Mem2Reg_i = 0;
    ALU_data_i = '0; writeData_i = '0; RDaddr_i = '0;
  endtask

  // Called just after a rising edge; returns just after the edge that retires v.
  task automatic run_vec(input vec_t v);
    int   n, stalls, reqs;
    logic prev_req, ack_now, stalled, aborted, finished;
    n = 0; stalls = 0; reqs = 0; prev_req = mem_req_o; finished = 0;
    drive_inputs(v);
    while (!finished) begin
      ack_now     = (v.lat > 0) && (n == v.lat);
      mem_ack_i   = ack_now;
      mem_rdata_i = ack_now ? v.rdata : $urandom;
      @(negedge clk_i);
      stalled = stall_o;
      if (stalled) stalls++;
      if (n >= 1)
        check($sformatf("%s/req_fields_c%0d", v.name, n),
              {31'd0, mem_req_o && mem_addr_o == v.alu && mem_we_o == v.wr &&
                      (!v.wr || mem_wdata_o == v.wdata)}, 32'd1);
      @(posedge clk_i); #1;
      if (mem_req_o && !prev_req) reqs++;
      aborted  = prev_req && !mem_req_o && !ack_now;
      prev_req = mem_req_o;
      finished = !stalled || aborted;
      if (!finished)
        check($sformatf("%s/bubble_c%0d", v.name, n), {30'd0, RegWrite_o, err_o}, 32'd0);
      n++;
      if (n > 3 * TO) begin
        check($sformatf("%s/cycle_budget", v.name), 32'(n), 32'(2 * TO));
        finished = 1;
      end
    end
    mem_ack_i = 0;
    check({v.name, "/stall_cycles"}, 32'(stalls), 32'(v.exp_stall));
    check({v.name, "/req_count"}, 32'(reqs), {31'd0, v.exp_req});
    check({v.name, "/err"}, {31'd0, err_o}, {31'd0, v.exp_err});
    check({v.name, "/RegWrite_o"}, {31'd0, RegWrite_o}, {31'd0, v.exp_rw});
    check({v.name, "/ReadData_o"}, ReadData_o, v.exp_rdata);
    check({v.name, "/req_after"}, {31'd0, mem_req_o}, 32'd0);
    if (!(v.exp_err && v.exp_req)) begin
      check({v.name, "/RDaddr_o"}, {27'd0, RDaddr_o}, {27'd0, v.rdd});
      check({v.name, "/ALU_data_o"}, ALU_data_o, v.alu);
      check({v.name, "/Mem2Reg_o"}, {31'd0, Mem2Reg_o}, {31'd0, v.m2r});
    end
    $display("txn %-14s alu=%08h lat=%0d stalls=%0d err=%0b rw=%0b rdata=%08h",
             v.name, v.alu, v.lat, stalls, err_o, RegWrite_o, ReadData_o);
  endtask

  initial begin
    vec_t        v;
    logic [31:0] model_rdata;
    int          kind;

    //            name            rd wr rw m2r alu           wdata         rd  lat rdata          stl err rw req rdata
    tbl[0] = '{"alu_op",        0, 0, 1, 0, 32'h1234,     32'h0,        5,  0, 32'h0,         0,  0, 1, 0, 32'h0};
    tbl[1] = '{"load_40",       1, 0, 1, 1, 32'h40,       32'h0,        7,  3, 32'hDEADBEEF,  3,  0, 1, 1, 32'hDEADBEEF};
    tbl[2] = '{"store_44",      0, 1, 0, 0, 32'h44,       32'hCAFE,     0,  1, 32'h0,         1,  0, 0, 1, 32'hDEADBEEF};
    tbl[3] = '{"load_41",       1, 0, 1, 1, 32'h41,       32'h0,        9,  0, 32'h0,         0,  1, 0, 0, 32'hDEADBEEF};
    tbl[4] = '{"store_46",      0, 1, 0, 0, 32'h46,       32'h55,       0,  0, 32'h0,         0,  1, 0, 0, 32'hDEADBEEF};
    tbl[5] = '{"load_timeout",  1, 0, 1, 1, 32'h80,       32'h0,        3,  0, 32'h0,         17, 1, 0, 1, 32'hDEADBEEF};
    tbl[6] = '{"load_ack16",    1, 0, 1, 1, 32'h84,       32'h0,        4,  16, 32'h0BADF00D, 16, 0, 1, 1, 32'h0BADF00D};
    tbl[7] = '{"alu_norw",      0, 0, 0, 0, 32'hFFFFFFFC, 32'h0,        31, 0, 32'h0,         0,  0, 0, 0, 32'h0BADF00D};

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    check("reset/outputs", {24'd0, mem_req_o, mem_we_o, stall_o, RegWrite_o, Mem2Reg_o, err_o, 2'd0}, 32'd0);
    check("reset/data", mem_addr_o | mem_wdata_o | ALU_data_o | ReadData_o | {27'd0, RDaddr_o}, 32'd0);
    rst_i = 0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Randomized transactions against a transaction-level model.
    model_rdata = tbl[7].exp_rdata;
    for (int t = 0; t < 60; t++) begin
      kind = int'($urandom_range(0, 3));
      v.name  = $sformatf("rnd%0d", t);
      v.rw    = 1'($urandom); v.m2r = 1'($urandom);
      v.rdd   = 5'($urandom); v.wdata = $urandom; v.rdata = $urandom;
      v.alu   = {$urandom, 2'b00} >> 2 << 2;
      v.rd    = (kind == 1); v.wr = (kind == 2);
      v.lat   = 0;
      if (kind == 3) begin
        if ($urandom_range(0, 1) == 1) v.rd = 1; else v.wr = 1;
        v.alu[1:0] = 2'($urandom_range(1, 3));
      end
      if (kind == 0 && $urandom_range(0, 1) == 1) v.alu[1:0] = 2'($urandom);
      if (kind == 1 || kind == 2) v.lat = int'($urandom_range(1, TO + 4));
      v.exp_rdata = model_rdata;
      if (!(v.rd || v.wr)) begin
        v.exp_stall = 0; v.exp_err = 0; v.exp_rw = v.rw; v.exp_req = 0;
      end else if (v.alu[1:0] != 2'b00) begin
        v.exp_stall = 0; v.exp_err = 1; v.exp_rw = 0; v.exp_req = 0;
      end else if (v.lat <= TO) begin
        v.exp_stall = v.lat; v.exp_err = 0; v.exp_rw = v.rw; v.exp_req = 1;
        if (v.rd) model_rdata = v.rdata;
        v.exp_rdata = model_rdata;
      end else begin
        v.lat = 0;
        v.exp_stall = TO + 1; v.exp_err = 1; v.exp_rw = 0; v.exp_req = 1;
      end
      run_vec(v);
    end

    // Reset in the middle of an open access, then a stray ack in IDLE.
    v = tbl[1];
    v.alu = 32'h100;
    drive_inputs(v);
    repeat (3) @(posedge clk_i);
    #1;
    check("rstwait/req_open", {31'd0, mem_req_o}, 32'd1);
    rst_i = 1;
    drive_nop();
    @(posedge clk_i); #1;
    check("rstwait/ctrl", {25'd0, mem_req_o, mem_we_o, RegWrite_o, Mem2Reg_o, err_o, 2'd0}, 32'd0);
    check("rstwait/data", mem_addr_o | mem_wdata_o | ALU_data_o | ReadData_o | {27'd0, RDaddr_o}, 32'd0);
    rst_i = 0;
    mem_ack_i = 1; mem_rdata_i = 32'h12345678;
    @(negedge clk_i);
    check("rstwait/stall_on_ack", {31'd0, stall_o}, 32'd0);
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    check("rstwait/ack_ignored", ReadData_o, 32'd0);
    check("rstwait/no_err_req", {30'd0, err_o, mem_req_o}, 32'd0);
    v = tbl[0];
    v.name = "post_reset_alu";
    run_vec(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
